// File: rtl/acq_trig_sched_if.sv
// Interface: acq_trig_sched_if
// Groups the control, timer and trigger-handshake signals of acq_trig_sched.
//   master : the scheduler side (drives timer control, trigger and status outputs)
//   slave  : the environment side (host registers, timer and sampler)
// Signals:
//   start, stop, num_trig            host run control
//   tmr_count, tmr_pulse_10ms/full   timer status
//   tmr_clr, tmr_ena                 timer control
//   trig_req/trig_ack                trigger handshake with the sampler
//   trig_stamp, trig_idx             trigger timestamp and acknowledged-trigger count
//   busy, done, err_miss, err_wrap   run status
interface acq_trig_sched_if #(
    parameter int unsigned TRIG_W = 16
) ();
    logic              start;
    logic              stop;
    logic [TRIG_W-1:0] num_trig;
    logic [27:0]       tmr_count;
    logic              tmr_pulse_10ms;
    logic              tmr_pulse_full;
    logic              tmr_clr;
    logic              tmr_ena;
    logic              trig_req;
    logic              trig_ack;
    logic [27:0]       trig_stamp;
    logic [TRIG_W-1:0] trig_idx;
    logic              busy;
    logic              done;
    logic              err_miss;
    logic              err_wrap;

    modport master (
        input  start, stop, num_trig, tmr_count, tmr_pulse_10ms, tmr_pulse_full, trig_ack,
        output tmr_clr, tmr_ena, trig_req, trig_stamp, trig_idx, busy, done, err_miss, err_wrap
    );

    modport slave (
        output start, stop, num_trig, tmr_count, tmr_pulse_10ms, tmr_pulse_full, trig_ack,
        input  tmr_clr, tmr_ena, trig_req, trig_stamp, trig_idx, busy, done, err_miss, err_wrap
    );
endinterface

// File: rtl/acq_trig_sched.sv
// Module: acq_trig_sched
// Sequences the 28-bit acquisition timer for one acquisition run: clears and enables the
// timer, counts its 10 ms pulses, raises a timestamped trigger every TICKS_PER_TRIG pulses,
// handshakes each trigger with the sampler and stops after num_trig triggers (0 = continuous).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  acq_trig_sched_if master modport (control, timer, trigger and status signals)
// All outputs are registered.
module acq_trig_sched #(
    parameter int unsigned TICKS_PER_TRIG = 10,
    parameter int unsigned TRIG_W         = 16
) (
    input logic              clk,
    input logic              rst,
    acq_trig_sched_if.master bus
);
    localparam int unsigned    TickW    = (TICKS_PER_TRIG > 1) ? $clog2(TICKS_PER_TRIG) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_TRIG - 1);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [TRIG_W-1:0] num_q, num_d;
    logic [TRIG_W-1:0] idx_q, idx_d;
    logic [27:0]       stamp_q, stamp_d;
    logic              clr_q, clr_d;
    logic              ena_q, ena_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              miss_q, miss_d;
    logic              wrap_q, wrap_d;
    logic              boundary;
    logic [TRIG_W-1:0] idx_inc;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        num_d      = num_q;
        idx_d      = idx_q;
        stamp_d    = stamp_q;
        clr_d      = 1'b0;
        ena_d      = ena_q;
        req_d      = req_q;
        done_d     = 1'b0;
        miss_d     = miss_q;
        wrap_d     = wrap_q;
        boundary   = bus.tmr_pulse_10ms && (tick_cnt_q == TickLast);
        idx_inc    = idx_q + TRIG_W'(1);

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d    = StClear;
                    num_d      = bus.num_trig;
                    tick_cnt_d = '0;
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    wrap_d     = 1'b0;
                    clr_d      = 1'b1;
                end
            end
            StClear: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRun;
                    ena_d   = 1'b1;
                end
            end
            StRun, StReq: begin
                // Abort wins over everything; counters, stamp and error flags hold.
                if (bus.stop) begin
                    state_d = StIdle;
                    ena_d   = 1'b0;
                    req_d   = 1'b0;
                end else begin
                    if (bus.tmr_pulse_full) wrap_d = 1'b1;
                    if (bus.tmr_pulse_10ms) begin
                        tick_cnt_d = boundary ? '0 : tick_cnt_q + TickW'(1);
                    end
                    if (state_q == StRun) begin
                        if (boundary) begin
                            state_d = StReq;
                            req_d   = 1'b1;
                            stamp_d = bus.tmr_count;
                        end
                    end else begin
                        // A boundary while a request is pending is dropped, even if the
                        // ack lands in the same cycle.
                        if (boundary) miss_d = 1'b1;
                        if (bus.trig_ack) begin
                            req_d = 1'b0;
                            idx_d = idx_inc;
                            if ((num_q != '0) && (idx_inc == num_q)) begin
                                state_d = StDone;
                                ena_d   = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = StRun;
                            end
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            stamp_q    <= '0;
            clr_q      <= 1'b0;
            ena_q      <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            miss_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            stamp_q    <= stamp_d;
            clr_q      <= clr_d;
            ena_q      <= ena_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            miss_q     <= miss_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.tmr_clr    = clr_q;
    assign bus.tmr_ena    = ena_q;
    assign bus.trig_req   = req_q;
    assign bus.trig_stamp = stamp_q;
    assign bus.trig_idx   = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err_miss   = miss_q;
    assign bus.err_wrap   = wrap_q;
endmodule

// File: tb/tb_acq_trig_sched.sv
// Testbench for acq_trig_sched with TICKS_PER_TRIG=2. A reference model tracks the expected
// run state; expected trigger stamps are queued when a boundary pulse is driven and popped
// when trig_req rises.
module tb_acq_trig_sched;
    localparam int unsigned Ticks = 2;
    localparam int unsigned TrigW = 16;

    logic clk;
    logic rst;

    acq_trig_sched_if #(.TRIG_W(TrigW)) bus ();

    acq_trig_sched #(
        .TICKS_PER_TRIG(Ticks),
        .TRIG_W        (TrigW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: m_st 0 = idle, 1 = running (RUN/REQ), 2 = done cycle.
    int              m_st;
    int unsigned     m_tick;
    bit              m_req;
    bit              m_miss;
    bit              m_wrap;
    logic [TrigW-1:0] m_idx;
    logic [TrigW-1:0] m_num;
    logic [27:0]     m_stamp;
    logic [27:0]     exp_q[$];
    int              rises[$];
    logic [27:0]     seen_stamps[$];
    int              done_seen;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".trig_req"},   bus.trig_req,   m_req);
        chk({tag, ".tmr_ena"},    bus.tmr_ena,    m_st == 1);
        chk({tag, ".tmr_clr"},    bus.tmr_clr,    1'b0);
        chk({tag, ".busy"},       bus.busy,       m_st != 0);
        chk({tag, ".done"},       bus.done,       m_st == 2);
        chk({tag, ".trig_idx"},   bus.trig_idx,   m_idx);
        chk({tag, ".err_miss"},   bus.err_miss,   m_miss);
        chk({tag, ".err_wrap"},   bus.err_wrap,   m_wrap);
        chk({tag, ".trig_stamp"}, bus.trig_stamp, m_stamp);
    endtask

    task automatic do_start(input logic [TrigW-1:0] num);
        bus.num_trig = num;
        bus.start    = 1'b1;
        tick(1);
        bus.start    = 1'b0;
        bus.num_trig = '0;  // the run must use the latched value
        chk("start.tmr_clr",  bus.tmr_clr,  1'b1);
        chk("start.tmr_ena",  bus.tmr_ena,  1'b0);
        chk("start.busy",     bus.busy,     1'b1);
        chk("start.err_miss", bus.err_miss, 1'b0);
        chk("start.err_wrap", bus.err_wrap, 1'b0);
        chk("start.trig_idx", bus.trig_idx, 16'd0);
        tick(1);
        chk("run.tmr_clr", bus.tmr_clr, 1'b0);
        chk("run.tmr_ena", bus.tmr_ena, 1'b1);
        chk("run.busy",    bus.busy,    1'b1);
        m_st   = 1;
        m_tick = 0;
        m_req  = 1'b0;
        m_idx  = '0;
        m_num  = num;
        m_miss = 1'b0;
        m_wrap = 1'b0;
    endtask

    // 10 ms pulse every 20 cycles; ack ack_delay cycles after each request (<0: never).
    task automatic run_window(input int ncyc, input int ack_delay);
        int rise_at;
        bit prev_req;
        rise_at  = -1;
        prev_req = bus.trig_req;
        for (int c = 0; c < ncyc; c++) begin
            bit          pls;
            bit          ack;
            bit          req_start;
            bit          bnd;
            logic [27:0] cnt;
            pls = ((c % 20) == 19);
            cnt = 28'hABCDE + 28'(c - 39) * 28'h101;
            ack = (ack_delay >= 0) && (rise_at >= 0) && (c == rise_at + ack_delay);
            bus.tmr_pulse_10ms = pls;
            bus.tmr_count      = cnt;
            bus.trig_ack       = ack;
            if (m_st == 2) begin
                m_st = 0;
            end else if (m_st == 1) begin
                req_start = m_req;
                bnd       = 1'b0;
                if (pls) begin
                    if (m_tick == Ticks - 1) begin
                        bnd    = 1'b1;
                        m_tick = 0;
                    end else begin
                        m_tick++;
                    end
                end
                if (req_start && ack) begin
                    m_req = 1'b0;
                    m_idx = m_idx + 1'b1;
                    if ((m_num != 0) && (m_idx == m_num)) m_st = 2;
                end
                if (bnd) begin
                    if (req_start) begin
                        m_miss = 1'b1;
                    end else begin
                        m_req   = 1'b1;
                        m_stamp = cnt;
                        exp_q.push_back(cnt);
                    end
                end
            end
            tick(1);
            if (bus.trig_req && !prev_req) begin
                rise_at = c;
                rises.push_back(c);
                seen_stamps.push_back(bus.trig_stamp);
                chk("req_rise_expected", exp_q.size(), 1);
                if (exp_q.size() != 0) chk("stamp_scoreboard", bus.trig_stamp, exp_q.pop_front());
            end
            if (bus.done) done_seen++;
            prev_req = bus.trig_req;
            chk_outputs("window");
        end
        bus.tmr_pulse_10ms = 1'b0;
        bus.trig_ack       = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.num_trig       = '0;
        bus.tmr_count      = '0;
        bus.tmr_pulse_10ms = 1'b0;
        bus.tmr_pulse_full = 1'b0;
        bus.trig_ack       = 1'b0;
        m_st = 0; m_tick = 0; m_req = 0; m_miss = 0; m_wrap = 0;
        m_idx = '0; m_num = '0; m_stamp = '0; done_seen = 0;

        // Reset values
        tick(3);
        chk_outputs("reset");
        rst = 1'b0;
        tick(2);

        // start together with stop in idle is ignored
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start_stop_idle.busy", bus.busy, 1'b0);
        chk("start_stop_idle.tmr_clr", bus.tmr_clr, 1'b0);

        // Start latency, then 3 triggers 40 cycles apart, first stamp 0xABCDE
        do_start(16'd3);
        rises.delete();
        seen_stamps.delete();
        done_seen = 0;
        run_window(140, 3);
        chk("run3.num_rises", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("run3.first_rise", rises[0], 39);
            chk("run3.gap1", rises[1] - rises[0], 40);
            chk("run3.gap2", rises[2] - rises[1], 40);
            chk("run3.first_stamp", seen_stamps[0], 28'hABCDE);
        end
        chk("run3.trig_idx", bus.trig_idx, 16'd3);
        chk("run3.done_pulses", done_seen, 1);
        chk("run3.tmr_ena", bus.tmr_ena, 1'b0);
        chk("run3.busy", bus.busy, 1'b0);

        // Missed trigger: no ack through the next boundary, late ack accepted
        do_start(16'd2);
        rises.delete();
        seen_stamps.delete();
        run_window(130, 46);
        chk("miss.err_miss", bus.err_miss, 1'b1);
        chk("miss.trig_idx", bus.trig_idx, 16'd1);
        chk("miss.trig_req", bus.trig_req, 1'b1);
        chk("miss.num_rises", rises.size(), 2);

        // stop and ack together in REQ: abort wins
        bus.stop     = 1'b1;
        bus.trig_ack = 1'b1;
        tick(1);
        bus.stop     = 1'b0;
        bus.trig_ack = 1'b0;
        m_st  = 0;
        m_req = 1'b0;
        chk_outputs("stop_ack");
        tick(1);
        chk_outputs("stop_ack_after");

        // Continuous mode for 6 triggers, then a timer wrap, then reset mid-run
        do_start(16'd0);
        rises.delete();
        seen_stamps.delete();
        run_window(260, 3);
        chk("cont.num_rises", rises.size(), 6);
        chk("cont.trig_idx", bus.trig_idx, 16'd6);
        bus.tmr_pulse_full = 1'b1;
        tick(1);
        bus.tmr_pulse_full = 1'b0;
        m_wrap = 1'b1;
        chk_outputs("wrap");
        chk("wrap.scoreboard_empty", exp_q.size(), 0);
        #2;
        rst = 1'b1;
        #2;
        chk("rst_mid.outputs",
            {bus.tmr_clr, bus.tmr_ena, bus.trig_req, bus.busy, bus.done, bus.err_miss,
             bus.err_wrap}, 7'd0);
        chk("rst_mid.trig_idx", bus.trig_idx, 16'd0);
        chk("rst_mid.trig_stamp", bus.trig_stamp, 28'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
